pos_regulator: RTL and testbench

Closed-loop pose regulator: compares a commanded target pose (X, Y, theta) against the dead-reckoned pose produced by the odometry integrator. Each control tick, it produces saturated proportional velocity commands (VX, VY, WZ) that are fed back into the velocity/kinematics path. It is the inverse of the odometry integrator:
- the integrator turns velocities into position;
- this block turns position error into velocity.

It uses one time-multiplexed subtract/multiply datapath for all three axes.

---
 rtl/pos_regulator_pkg.sv | 56 +++++
 rtl/pos_regulator_if.sv | 38 +++
 rtl/pos_regulator_alu.sv | 65 ++++++
 rtl/pos_regulator.sv | 145 ++++++++++++++
 tb/tb_pos_regulator.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pos_regulator_pkg.sv
// Shared types, fixed-point constants and sign-magnitude helpers for the pose regulator
// and the velocity-loop blocks that reuse its ALU.
package pos_regulator_pkg;

  localparam int unsigned N_WIDTH = 17;
  localparam int unsigned Q_WIDTH = 8;
  localparam int unsigned M_WIDTH = N_WIDTH - 1;
  localparam int unsigned P_WIDTH = 2 * N_WIDTH;

  localparam logic [N_WIDTH-1:0] SM_ZERO = '0;
  localparam logic [N_WIDTH-1:0] MAG_180 = N_WIDTH'(180 * (1 << Q_WIDTH));
  localparam logic [N_WIDTH-1:0] MAG_360 = N_WIDTH'(360 * (1 << Q_WIDTH));
  localparam logic [N_WIDTH-1:0] MAG_MAX = {1'b0, {M_WIDTH{1'b1}}};

  typedef enum logic [3:0] {
    StIdle, StLoad,
    StSubX, StMulX, StSatX,
    StSubY, StMulY, StSatY,
    StSubT, StMulT, StSatT,
    StCommit
  } state_e;

  // One extra magnitude bit so differences and 360-degree headings fit before wrapping.
  typedef struct packed {
    logic               sgn;
    logic [N_WIDTH-1:0] mag;
  } sm_wide_t;

  function automatic sm_wide_t sm_add(sm_wide_t a, sm_wide_t b);
    sm_wide_t r;
    if (a.sgn == b.sgn) begin
      r.sgn = a.sgn;
      r.mag = a.mag + b.mag;
    end else if (a.mag >= b.mag) begin
      r.sgn = a.sgn;
      r.mag = a.mag - b.mag;
    end else begin
      r.sgn = b.sgn;
      r.mag = b.mag - a.mag;
    end
    if (r.mag == '0) r.sgn = 1'b0;
    return r;
  endfunction

  function automatic sm_wide_t sm_sub(sm_wide_t a, sm_wide_t b);
    sm_wide_t nb;
    nb     = b;
    nb.sgn = ~b.sgn;
    return sm_add(a, nb);
  endfunction

  function automatic logic sm_mag_le(logic [N_WIDTH-1:0] a, logic [N_WIDTH-1:0] b);
    return a <= b;
  endfunction

endpackage

// File: rtl/pos_regulator_if.sv
// Command/status bundle of the pose regulator: mode, tick, pose inputs and velocity outputs.
interface pos_regulator_if;
  import pos_regulator_pkg::*;

  logic               POS_REGULATOR_ENABLE_InLow;
  logic               POS_REGULATOR_TICK_InLow;
  logic [N_WIDTH-1:0] POS_REGULATOR_TGTX_InBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_TGTY_InBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_TGTTH_InBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_POSX_InBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_POSY_InBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_THETA_InBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_VX_OutBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_VY_OutBus;
  logic [N_WIDTH-1:0] POS_REGULATOR_WZ_OutBus;
  logic               POS_REGULATOR_ARRIVED_OutHigh;
  logic               POS_REGULATOR_BUSY_OutHigh;
  logic               POS_REGULATOR_DONE_OutHigh;

  modport master (
    output POS_REGULATOR_ENABLE_InLow, POS_REGULATOR_TICK_InLow,
    output POS_REGULATOR_TGTX_InBus, POS_REGULATOR_TGTY_InBus, POS_REGULATOR_TGTTH_InBus,
    output POS_REGULATOR_POSX_InBus, POS_REGULATOR_POSY_InBus, POS_REGULATOR_THETA_InBus,
    input  POS_REGULATOR_VX_OutBus, POS_REGULATOR_VY_OutBus, POS_REGULATOR_WZ_OutBus,
    input  POS_REGULATOR_ARRIVED_OutHigh, POS_REGULATOR_BUSY_OutHigh,
    input  POS_REGULATOR_DONE_OutHigh
  );

  modport slave (
    input  POS_REGULATOR_ENABLE_InLow, POS_REGULATOR_TICK_InLow,
    input  POS_REGULATOR_TGTX_InBus, POS_REGULATOR_TGTY_InBus, POS_REGULATOR_TGTTH_InBus,
    input  POS_REGULATOR_POSX_InBus, POS_REGULATOR_POSY_InBus, POS_REGULATOR_THETA_InBus,
    output POS_REGULATOR_VX_OutBus, POS_REGULATOR_VY_OutBus, POS_REGULATOR_WZ_OutBus,
    output POS_REGULATOR_ARRIVED_OutHigh, POS_REGULATOR_BUSY_OutHigh,
    output POS_REGULATOR_DONE_OutHigh
  );

endinterface

// File: rtl/pos_regulator_alu.sv
// Combinational sign-magnitude datapath: subtract (with optional heading wrap) plus
// tolerance compare, proportional multiply with overflow detect, and magnitude clamp.
module pos_regulator_alu
  import pos_regulator_pkg::*;
(
  input  logic [N_WIDTH-1:0] i_a,
  input  logic [N_WIDTH-1:0] i_b,
  input  logic               i_heading,
  input  logic [M_WIDTH-1:0] i_tol,
  input  logic [N_WIDTH-1:0] i_err,
  input  logic [N_WIDTH-1:0] i_kp,
  input  logic [N_WIDTH-1:0] i_prod,
  input  logic               i_ovf,
  input  logic [M_WIDTH-1:0] i_lim,
  output logic [N_WIDTH-1:0] o_diff,
  output logic               o_in_tol,
  output logic [N_WIDTH-1:0] o_prod,
  output logic               o_ovf,
  output logic [N_WIDTH-1:0] o_sat
);

  sm_wide_t           w_a;
  sm_wide_t           w_b;
  sm_wide_t           w_d;
  sm_wide_t           w_e;
  logic [P_WIDTH-1:0] w_full;
  logic [P_WIDTH-1:0] w_shift;
  logic [M_WIDTH-1:0] w_pmag;
  logic [M_WIDTH-1:0] w_smag;

  always_comb begin
    // Headings are unsigned [0,360); all other buses carry a sign bit.
    if (i_heading) begin
      w_a = '{sgn: 1'b0, mag: i_a};
      w_b = '{sgn: 1'b0, mag: i_b};
    end else begin
      w_a = '{sgn: i_a[N_WIDTH-1], mag: {1'b0, i_a[N_WIDTH-2:0]}};
      w_b = '{sgn: i_b[N_WIDTH-1], mag: {1'b0, i_b[N_WIDTH-2:0]}};
    end
    w_d = sm_sub(w_a, w_b);
    w_e = w_d;
    if (i_heading && (w_d.mag > MAG_180)) begin
      w_e.sgn = ~w_d.sgn;
      w_e.mag = MAG_360 - w_d.mag;
    end
    if (w_e.mag > MAG_MAX) o_diff = {w_e.sgn, MAG_MAX[M_WIDTH-1:0]};
    else                   o_diff = {w_e.sgn, w_e.mag[M_WIDTH-1:0]};
    o_in_tol = sm_mag_le({1'b0, o_diff[M_WIDTH-1:0]}, {1'b0, i_tol});
  end

  always_comb begin
    w_full  = P_WIDTH'(i_err[M_WIDTH-1:0]) * P_WIDTH'(i_kp[M_WIDTH-1:0]);
    w_shift = w_full >> Q_WIDTH;
    w_pmag  = w_shift[M_WIDTH-1:0];
    o_ovf   = |w_shift[P_WIDTH-1:M_WIDTH];
    o_prod  = {(i_err[N_WIDTH-1] ^ i_kp[N_WIDTH-1]) & ((w_pmag != '0) | o_ovf), w_pmag};
  end

  always_comb begin
    if (i_ovf || (i_prod[M_WIDTH-1:0] > i_lim)) w_smag = i_lim;
    else                                        w_smag = i_prod[M_WIDTH-1:0];
    o_sat = {i_prod[N_WIDTH-1] & (w_smag != '0), w_smag};
  end

endmodule

// File: rtl/pos_regulator.sv
// Pose regulator: per tick, snapshots target and current pose and walks one shared ALU
// through X, Y and heading to produce saturated proportional velocity commands.
module pos_regulator
  import pos_regulator_pkg::*;
#(
  parameter logic [N_WIDTH-1:0] KP_XY   = 17'h00080,
  parameter logic [N_WIDTH-1:0] KP_TH   = 17'h00010,
  parameter logic [N_WIDTH-1:0] VMAX_XY = 17'h01400,
  parameter logic [N_WIDTH-1:0] WMAX    = 17'h00800,
  parameter logic [N_WIDTH-1:0] TOL_XY  = 17'h00080,
  parameter logic [N_WIDTH-1:0] TOL_TH  = 17'h00100
) (
  input  logic           POS_REGULATOR_CLOCK_50,
  input  logic           POS_REGULATOR_Reset_InHigh,
  pos_regulator_if.slave io_reg
);

  state_e             r_state;
  logic [N_WIDTH-1:0] r_tgt_x, r_tgt_y, r_tgt_th, r_pos_x, r_pos_y, r_pos_th;
  logic [N_WIDTH-1:0] r_err, r_prod, r_stg_x, r_stg_y, r_stg_t, r_vx, r_vy, r_wz;
  logic               r_ovf, r_arrived, r_busy, r_done;
  logic [2:0]         r_tol;

  logic [N_WIDTH-1:0] w_a, w_b, w_kp, w_diff, w_prod, w_sat;
  logic [M_WIDTH-1:0] w_tol, w_lim;
  logic               w_heading, w_in_tol, w_ovf;

  always_comb begin
    w_a       = r_tgt_x;
    w_b       = r_pos_x;
    w_heading = 1'b0;
    w_tol     = TOL_XY[M_WIDTH-1:0];
    w_kp      = KP_XY;
    w_lim     = VMAX_XY[M_WIDTH-1:0];
    case (r_state)
      StSubY, StMulY, StSatY: begin
        w_a = r_tgt_y;
        w_b = r_pos_y;
      end
      StSubT, StMulT, StSatT: begin
        w_a       = r_tgt_th;
        w_b       = r_pos_th;
        w_heading = 1'b1;
        w_tol     = TOL_TH[M_WIDTH-1:0];
        w_kp      = KP_TH;
        w_lim     = WMAX[M_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  pos_regulator_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_heading(w_heading),
    .i_tol    (w_tol),
    .i_err    (r_err),
    .i_kp     (w_kp),
    .i_prod   (r_prod),
    .i_ovf    (r_ovf),
    .i_lim    (w_lim),
    .o_diff   (w_diff),
    .o_in_tol (w_in_tol),
    .o_prod   (w_prod),
    .o_ovf    (w_ovf),
    .o_sat    (w_sat)
  );

  always_ff @(posedge POS_REGULATOR_CLOCK_50) begin
    if (POS_REGULATOR_Reset_InHigh) begin
      r_state   <= StIdle;
      r_tgt_x   <= SM_ZERO;
      r_tgt_y   <= SM_ZERO;
      r_tgt_th  <= SM_ZERO;
      r_pos_x   <= SM_ZERO;
      r_pos_y   <= SM_ZERO;
      r_pos_th  <= SM_ZERO;
      r_err     <= SM_ZERO;
      r_prod    <= SM_ZERO;
      r_ovf     <= 1'b0;
      r_tol     <= '0;
      r_stg_x   <= SM_ZERO;
      r_stg_y   <= SM_ZERO;
      r_stg_t   <= SM_ZERO;
      r_vx      <= SM_ZERO;
      r_vy      <= SM_ZERO;
      r_wz      <= SM_ZERO;
      r_arrived <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (io_reg.POS_REGULATOR_ENABLE_InLow) begin
      r_state   <= StIdle;
      r_vx      <= SM_ZERO;
      r_vy      <= SM_ZERO;
      r_wz      <= SM_ZERO;
      r_arrived <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: if (!io_reg.POS_REGULATOR_TICK_InLow) begin
          r_state <= StLoad;
          r_busy  <= 1'b1;
        end
        StLoad: begin
          r_tgt_x  <= io_reg.POS_REGULATOR_TGTX_InBus;
          r_tgt_y  <= io_reg.POS_REGULATOR_TGTY_InBus;
          r_tgt_th <= io_reg.POS_REGULATOR_TGTTH_InBus;
          r_pos_x  <= io_reg.POS_REGULATOR_POSX_InBus;
          r_pos_y  <= io_reg.POS_REGULATOR_POSY_InBus;
          r_pos_th <= io_reg.POS_REGULATOR_THETA_InBus;
          r_state  <= StSubX;
        end
        StSubX: begin r_err <= w_diff; r_tol[0] <= w_in_tol; r_state <= StMulX; end
        StSubY: begin r_err <= w_diff; r_tol[1] <= w_in_tol; r_state <= StMulY; end
        StSubT: begin r_err <= w_diff; r_tol[2] <= w_in_tol; r_state <= StMulT; end
        StMulX: begin r_prod <= w_prod; r_ovf <= w_ovf; r_state <= StSatX; end
        StMulY: begin r_prod <= w_prod; r_ovf <= w_ovf; r_state <= StSatY; end
        StMulT: begin r_prod <= w_prod; r_ovf <= w_ovf; r_state <= StSatT; end
        StSatX: begin r_stg_x <= w_sat; r_state <= StSubY; end
        StSatY: begin r_stg_y <= w_sat; r_state <= StSubT; end
        StSatT: begin r_stg_t <= w_sat; r_state <= StCommit; end
        StCommit: begin
          r_vx      <= (&r_tol) ? SM_ZERO : r_stg_x;
          r_vy      <= (&r_tol) ? SM_ZERO : r_stg_y;
          r_wz      <= (&r_tol) ? SM_ZERO : r_stg_t;
          r_arrived <= &r_tol;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_reg.POS_REGULATOR_VX_OutBus       = r_vx;
  assign io_reg.POS_REGULATOR_VY_OutBus       = r_vy;
  assign io_reg.POS_REGULATOR_WZ_OutBus       = r_wz;
  assign io_reg.POS_REGULATOR_ARRIVED_OutHigh = r_arrived;
  assign io_reg.POS_REGULATOR_BUSY_OutHigh    = r_busy;
  assign io_reg.POS_REGULATOR_DONE_OutHigh    = r_done;

endmodule

// File: tb/tb_pos_regulator.sv
// Directed bench for pos_regulator with unity gains; expected values are hand-computed.
module tb_pos_regulator;

  localparam int EvNone = 0, EvTick = 1, EvEnable = 2, EvReset = 3, EvScramble = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   done_cnt;
  int   done_k;
  int   busy_cnt;

  pos_regulator_if u_if ();

  pos_regulator #(
    .KP_XY(17'h00100),
    .KP_TH(17'h00100)
  ) u_dut (
    .POS_REGULATOR_CLOCK_50    (clk),
    .POS_REGULATOR_Reset_InHigh(rst),
    .io_reg                    (u_if.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [16:0] vx, input logic [16:0] vy,
                         input logic [16:0] wz, input logic arr);
    chk({tag, ".vx"}, 32'(u_if.POS_REGULATOR_VX_OutBus), 32'(vx));
    chk({tag, ".vy"}, 32'(u_if.POS_REGULATOR_VY_OutBus), 32'(vy));
    chk({tag, ".wz"}, 32'(u_if.POS_REGULATOR_WZ_OutBus), 32'(wz));
    chk({tag, ".arrived"}, 32'(u_if.POS_REGULATOR_ARRIVED_OutHigh), 32'(arr));
  endtask

  task automatic chk_norm(input string tag);
    chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, ".done_cycle"}, 32'(done_k), 32'd11);
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd10);
  endtask

  task automatic chk_abort(input string tag);
    chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd0);
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd6);
    chk({tag, ".busy_end"}, 32'(u_if.POS_REGULATOR_BUSY_OutHigh), 32'd0);
  endtask

  // Drives one tick (sampled at E0) then observes 16 cycles, injecting an optional event.
  task automatic run(input logic [16:0] tx, input logic [16:0] ty, input logic [16:0] tth,
                     input logic [16:0] px, input logic [16:0] py, input logic [16:0] pth,
                     input int ev_k, input int ev);
    u_if.POS_REGULATOR_TGTX_InBus  = tx;
    u_if.POS_REGULATOR_TGTY_InBus  = ty;
    u_if.POS_REGULATOR_TGTTH_InBus = tth;
    u_if.POS_REGULATOR_POSX_InBus  = px;
    u_if.POS_REGULATOR_POSY_InBus  = py;
    u_if.POS_REGULATOR_THETA_InBus = pth;
    u_if.POS_REGULATOR_TICK_InLow  = 1'b0;
    @(posedge clk); #1;
    u_if.POS_REGULATOR_TICK_InLow = 1'b1;
    done_cnt = 0;
    done_k   = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (u_if.POS_REGULATOR_DONE_OutHigh) begin
        done_cnt++;
        done_k = k;
      end
      if (u_if.POS_REGULATOR_BUSY_OutHigh) busy_cnt++;
      if (k == ev_k + 1) begin
        u_if.POS_REGULATOR_TICK_InLow   = 1'b1;
        u_if.POS_REGULATOR_ENABLE_InLow = 1'b0;
        rst = 1'b0;
      end
      if (k == ev_k) begin
        case (ev)
          EvTick:     u_if.POS_REGULATOR_TICK_InLow = 1'b0;
          EvEnable:   u_if.POS_REGULATOR_ENABLE_InLow = 1'b1;
          EvReset:    rst = 1'b1;
          EvScramble: u_if.POS_REGULATOR_TGTX_InBus = 17'h01234;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    u_if.POS_REGULATOR_ENABLE_InLow = 1'b0;
    u_if.POS_REGULATOR_TICK_InLow   = 1'b1;
    u_if.POS_REGULATOR_TGTX_InBus   = '0;
    u_if.POS_REGULATOR_TGTY_InBus   = '0;
    u_if.POS_REGULATOR_TGTTH_InBus  = '0;
    u_if.POS_REGULATOR_POSX_InBus   = '0;
    u_if.POS_REGULATOR_POSY_InBus   = '0;
    u_if.POS_REGULATOR_THETA_InBus  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_out("reset", 17'h0, 17'h0, 17'h0, 1'b0);
    chk("reset.busy", 32'(u_if.POS_REGULATOR_BUSY_OutHigh), 32'd0);
    chk("reset.done", 32'(u_if.POS_REGULATOR_DONE_OutHigh), 32'd0);

    run(17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_norm("zero");
    chk_out("zero", 17'h0, 17'h0, 17'h0, 1'b1);

    run(17'h00A00, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_norm("x_pos");
    chk_out("x_pos", 17'h00A00, 17'h0, 17'h0, 1'b0);

    run(17'h00A00, 17'h0, 17'h0, 17'h00C00, 17'h0, 17'h0, 0, EvNone);
    chk_out("x_neg", 17'h10200, 17'h0, 17'h0, 1'b0);

    run(17'h03200, 17'h16400, 17'h0, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_out("xy_clamp", 17'h01400, 17'h11400, 17'h0, 1'b0);

    run(17'h0, 17'h0, 17'h00A00, 17'h0, 17'h0, 17'h15E00, 0, EvNone);
    chk_out("wrap_pos", 17'h0, 17'h0, 17'h00800, 1'b0);

    run(17'h0, 17'h0, 17'h15E00, 17'h0, 17'h0, 17'h00A00, 0, EvNone);
    chk_out("wrap_neg", 17'h0, 17'h0, 17'h10800, 1'b0);

    run(17'h0, 17'h0, 17'h00200, 17'h0, 17'h0, 17'h16700, 0, EvNone);
    chk_out("wrap_small", 17'h0, 17'h0, 17'h00300, 1'b0);

    run(17'h00066, 17'h1004D, 17'h00080, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_out("tol_in", 17'h0, 17'h0, 17'h0, 1'b1);

    run(17'h0009A, 17'h1004D, 17'h00080, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_out("tol_out", 17'h0009A, 17'h1004D, 17'h00080, 1'b0);

    run(17'h00080, 17'h10080, 17'h00100, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_out("tol_edge", 17'h0, 17'h0, 17'h0, 1'b1);

    run(17'h00081, 17'h10080, 17'h00100, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_out("tol_over", 17'h00081, 17'h10080, 17'h00100, 1'b0);

    run(17'h10500, 17'h01000, 17'h0, 17'h10500, 17'h0, 17'h0, 0, EvNone);
    chk_out("neg_zero", 17'h0, 17'h01000, 17'h0, 1'b0);

    run(17'h00300, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 1, EvScramble);
    chk_norm("snapshot");
    chk_out("snapshot", 17'h00300, 17'h0, 17'h0, 1'b0);

    run(17'h00A00, 17'h00200, 17'h0, 17'h0, 17'h0, 17'h0, 4, EvTick);
    chk_norm("tick_busy");
    chk_out("tick_busy", 17'h00A00, 17'h00200, 17'h0, 1'b0);

    run(17'h00500, 17'h00500, 17'h00500, 17'h0, 17'h0, 17'h0, 6, EvEnable);
    chk_abort("enable_abort");
    chk_out("enable_abort", 17'h0, 17'h0, 17'h0, 1'b0);

    run(17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_norm("recover1");
    chk_out("recover1", 17'h0, 17'h0, 17'h0, 1'b1);

    run(17'h00700, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 6, EvReset);
    chk_abort("reset_abort");
    chk_out("reset_abort", 17'h0, 17'h0, 17'h0, 1'b0);

    run(17'h00A00, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 0, EvNone);
    chk_norm("recover2");
    chk_out("recover2", 17'h00A00, 17'h0, 17'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
